// File: rtl/sdram_ch1_wrq.sv
// Posted-write queue and request sequencer in front of SDRAM channel 1.
// Writes are buffered in a small FIFO; a read waits until every earlier write has been issued.
module sdram_ch1_wrq #(
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          cpu_valid,
  input  logic          cpu_rnw,
  input  logic [25:0]   cpu_addr,
  input  logic [63:0]   cpu_din,
  input  logic [7:0]    cpu_be,
  output logic          cpu_ack,
  output logic [63:0]   cpu_dout,
  output logic          cpu_rvalid,
  output logic [LW-1:0] wq_level,
  output logic [25:0]   ch1_addr,
  output logic [63:0]   ch1_din,
  output logic [7:0]    ch1_be,
  output logic          ch1_rnw,
  output logic          ch1_req,
  input  logic          ch1_ready,
  input  logic [63:0]   ch1_dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_W, WAIT_R, RDONE} state_t;

  state_t        state_q, state_d;
  logic [25:0]   fifo_addr [DEPTH];
  logic [63:0]   fifo_din  [DEPTH];
  logic [7:0]    fifo_be   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] wq_level_q, wq_level_d;
  logic          rd_busy_q, rd_busy_d;
  logic [25:0]   rd_addr_q, rd_addr_d;
  logic [25:0]   ch1_addr_q, ch1_addr_d;
  logic [63:0]   ch1_din_q, ch1_din_d;
  logic [7:0]    ch1_be_q, ch1_be_d;
  logic          ch1_rnw_q, ch1_rnw_d;
  logic          ch1_req_q, ch1_req_d;
  logic [63:0]   cpu_dout_q, cpu_dout_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          wq_full, wr_push, wr_pop, rd_accept;

  // Full uses the registered level only, so a same-cycle pop never frees a slot early.
  assign wq_full   = (wq_level_q == LW'(DEPTH));
  assign wr_push   = init_n & cpu_valid & ~cpu_rnw & ~wq_full & ~rd_busy_q;
  assign rd_accept = init_n & cpu_valid & cpu_rnw & ~rd_busy_q;
  assign wr_pop    = (state_q == WAIT_W) & ch1_ready;
  assign cpu_ack   = wr_push | rd_accept;

  always_ff @(posedge clk) begin
    if (wr_push) begin
      fifo_addr[wr_ptr_q] <= cpu_addr;
      fifo_din[wr_ptr_q]  <= cpu_din;
      fifo_be[wr_ptr_q]   <= cpu_be;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = wr_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wq_level_d = wq_level_q + LW'(wr_push) - LW'(wr_pop);
  end

  always_comb begin
    state_d      = state_q;
    rd_busy_d    = rd_busy_q;
    rd_addr_d    = rd_addr_q;
    ch1_addr_d   = ch1_addr_q;
    ch1_din_d    = ch1_din_q;
    ch1_be_d     = ch1_be_q;
    ch1_rnw_d    = ch1_rnw_q;
    ch1_req_d    = 1'b0;
    cpu_dout_d   = cpu_dout_q;
    cpu_rvalid_d = 1'b0;
    if (rd_accept) begin
      rd_busy_d = 1'b1;
      rd_addr_d = cpu_addr;
    end
    case (state_q)
      IDLE: begin
        if (wq_level_q != '0) begin
          ch1_addr_d = fifo_addr[rd_ptr_q];
          ch1_din_d  = fifo_din[rd_ptr_q];
          ch1_be_d   = fifo_be[rd_ptr_q];
          ch1_rnw_d  = 1'b0;
          ch1_req_d  = 1'b1;
          state_d    = WAIT_W;
        end else if (wr_push) begin
          // Empty queue: issue the incoming write straight away; it also lands as the FIFO head.
          ch1_addr_d = cpu_addr;
          ch1_din_d  = cpu_din;
          ch1_be_d   = cpu_be;
          ch1_rnw_d  = 1'b0;
          ch1_req_d  = 1'b1;
          state_d    = WAIT_W;
        end else if (rd_busy_q) begin
          ch1_addr_d = rd_addr_q;
          ch1_din_d  = '0;
          ch1_be_d   = 8'hFF;
          ch1_rnw_d  = 1'b1;
          ch1_req_d  = 1'b1;
          state_d    = WAIT_R;
        end
      end
      WAIT_W: begin
        if (ch1_ready) state_d = IDLE;
      end
      WAIT_R: begin
        if (ch1_ready) begin
          cpu_dout_d   = ch1_dout;
          cpu_rvalid_d = 1'b1;
          state_d      = RDONE;
        end
      end
      RDONE: begin
        rd_busy_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wq_level_q   <= '0;
      rd_busy_q    <= 1'b0;
      rd_addr_q    <= '0;
      ch1_addr_q   <= '0;
      ch1_din_q    <= '0;
      ch1_be_q     <= '0;
      ch1_rnw_q    <= 1'b0;
      ch1_req_q    <= 1'b0;
      cpu_dout_q   <= '0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wq_level_q   <= wq_level_d;
      rd_busy_q    <= rd_busy_d;
      rd_addr_q    <= rd_addr_d;
      ch1_addr_q   <= ch1_addr_d;
      ch1_din_q    <= ch1_din_d;
      ch1_be_q     <= ch1_be_d;
      ch1_rnw_q    <= ch1_rnw_d;
      ch1_req_q    <= ch1_req_d;
      cpu_dout_q   <= cpu_dout_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  assign wq_level   = wq_level_q;
  assign ch1_addr   = ch1_addr_q;
  assign ch1_din    = ch1_din_q;
  assign ch1_be     = ch1_be_q;
  assign ch1_rnw    = ch1_rnw_q;
  assign ch1_req    = ch1_req_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_sdram_ch1_wrq.sv
// Directed bench for sdram_ch1_wrq: the bench plays both the CPU and the channel-1 controller.
module tb_sdram_ch1_wrq;

  logic        clk = 1'b0;
  logic        init_n;
  logic        cpu_valid, cpu_rnw;
  logic [25:0] cpu_addr;
  logic [63:0] cpu_din;
  logic [7:0]  cpu_be;
  logic        cpu_ack;
  logic [63:0] cpu_dout;
  logic        cpu_rvalid;
  logic [2:0]  wq_level;
  logic [25:0] ch1_addr;
  logic [63:0] ch1_din;
  logic [7:0]  ch1_be;
  logic        ch1_rnw, ch1_req, ch1_ready;
  logic [63:0] ch1_dout;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [25:0] t3_addr [5] = '{26'h0, 26'h4, 26'h8, 26'hC, 26'h10};

  always #5 clk = ~clk;

  sdram_ch1_wrq #(.DEPTH(4)) dut (
    .clk(clk), .init_n(init_n),
    .cpu_valid(cpu_valid), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_be(cpu_be), .cpu_ack(cpu_ack),
    .cpu_dout(cpu_dout), .cpu_rvalid(cpu_rvalid), .wq_level(wq_level),
    .ch1_addr(ch1_addr), .ch1_din(ch1_din), .ch1_be(ch1_be),
    .ch1_rnw(ch1_rnw), .ch1_req(ch1_req), .ch1_ready(ch1_ready),
    .ch1_dout(ch1_dout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic rnw, input logic [25:0] a, input logic [63:0] d, input logic [7:0] b);
    cpu_valid = 1'b1;
    cpu_rnw   = rnw;
    cpu_addr  = a;
    cpu_din   = d;
    cpu_be    = b;
    #1;
  endtask

  // Waits (bounded) for the next request, checks it, then answers it a few cycles later.
  task automatic serve(input string tag, input logic [25:0] exp_addr, input logic exp_rnw,
                       input logic [63:0] rdata);
    int n = 0;
    while (ch1_req !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check({tag, " req"}, {63'd0, ch1_req}, 64'd1);
    check({tag, " addr"}, {38'd0, ch1_addr}, {38'd0, exp_addr});
    check({tag, " rnw"}, {63'd0, ch1_rnw}, {63'd0, exp_rnw});
    cyc();
    check({tag, " pulse"}, {63'd0, ch1_req}, 64'd0);
    cyc();
    check({tag, " held"}, {38'd0, ch1_addr}, {38'd0, exp_addr});
    ch1_ready = 1'b1;
    ch1_dout  = rdata;
    cyc();
    ch1_ready = 1'b0;
    ch1_dout  = '0;
    check({tag, " gap"}, {63'd0, ch1_req}, 64'd0);
  endtask

  initial begin
    init_n = 1'b1; cpu_valid = 1'b0; cpu_rnw = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_be = '0;
    ch1_ready = 1'b0; ch1_dout = '0;
    #1 init_n = 1'b0;
    cyc(); cyc();

    // T1: reset held
    present(1'b0, 26'h100, 64'h1, 8'hFF);
    check("t1 ack", {63'd0, cpu_ack}, 64'd0);
    check("t1 req", {63'd0, ch1_req}, 64'd0);
    check("t1 level", {61'd0, wq_level}, 64'd0);
    check("t1 rvalid", {63'd0, cpu_rvalid}, 64'd0);
    cpu_valid = 1'b0;
    init_n = 1'b1;
    cyc();

    // T2: single write, controller answers 8 cycles after the request
    present(1'b0, 26'h100, 64'h1122334455667788, 8'hFF);
    check("t2 ack", {63'd0, cpu_ack}, 64'd1);
    cyc();
    cpu_valid = 1'b0;
    check("t2 req", {63'd0, ch1_req}, 64'd1);
    check("t2 addr", {38'd0, ch1_addr}, 64'h100);
    check("t2 din", ch1_din, 64'h1122334455667788);
    check("t2 be", {56'd0, ch1_be}, 64'hFF);
    check("t2 rnw", {63'd0, ch1_rnw}, 64'd0);
    check("t2 level1", {61'd0, wq_level}, 64'd1);
    for (int i = 1; i < 8; i++) begin
      cyc();
      check("t2 req low", {63'd0, ch1_req}, 64'd0);
      check("t2 addr held", {38'd0, ch1_addr}, 64'h100);
    end
    ch1_ready = 1'b1;
    cyc();
    ch1_ready = 1'b0;
    check("t2 level0", {61'd0, wq_level}, 64'd0);
    check("t2 no reissue", {63'd0, ch1_req}, 64'd0);
    cyc();

    // T3: fill the queue with the controller stalled
    for (int i = 0; i < 4; i++) begin
      present(1'b0, t3_addr[i], 64'hA0 + 64'(i), 8'h0F);
      check("t3 ack", {63'd0, cpu_ack}, 64'd1);
      cyc();
    end
    check("t3 level full", {61'd0, wq_level}, 64'd4);
    check("t3 first addr", {38'd0, ch1_addr}, 64'h0);
    present(1'b0, t3_addr[4], 64'hA4, 8'h0F);
    check("t3 full nack", {63'd0, cpu_ack}, 64'd0);
    cyc(); cyc();
    check("t3 still nack", {63'd0, cpu_ack}, 64'd0);
    ch1_ready = 1'b1;
    #1;
    check("t3 nack on ready", {63'd0, cpu_ack}, 64'd0);
    cyc();
    ch1_ready = 1'b0;
    check("t3 ack after ready", {63'd0, cpu_ack}, 64'd1);
    check("t3 level3", {61'd0, wq_level}, 64'd3);
    cyc();
    cpu_valid = 1'b0;
    check("t3 level refill", {61'd0, wq_level}, 64'd4);
    for (int i = 1; i < 5; i++) serve("t3 drain", t3_addr[i], 1'b0, 64'd0);
    check("t3 level empty", {61'd0, wq_level}, 64'd0);
    cyc();

    // T4/T5: two writes, then a read; a write presented while the read is pending
    present(1'b0, 26'h200, 64'hB0, 8'hFF);
    check("t4 w0 ack", {63'd0, cpu_ack}, 64'd1);
    cyc();
    check("t4 w0 req", {63'd0, ch1_req}, 64'd1);
    check("t4 w0 addr", {38'd0, ch1_addr}, 64'h200);
    present(1'b0, 26'h208, 64'hB1, 8'hFF);
    check("t4 w1 ack", {63'd0, cpu_ack}, 64'd1);
    cyc();
    present(1'b1, 26'h40, 64'h0, 8'h00);
    check("t4 rd ack", {63'd0, cpu_ack}, 64'd1);
    cyc();
    present(1'b0, 26'h300, 64'hC0C0, 8'h0F);
    check("t5 blocked", {63'd0, cpu_ack}, 64'd0);
    ch1_ready = 1'b1;
    cyc();
    ch1_ready = 1'b0;
    serve("t4 w1", 26'h208, 1'b0, 64'd0);
    check("t5 blocked w", {63'd0, cpu_ack}, 64'd0);
    check("t4 no early rvalid", {63'd0, cpu_rvalid}, 64'd0);
    serve("t4 rd", 26'h40, 1'b1, 64'hDEADBEEF00C0FFEE);
    check("t4 rvalid", {63'd0, cpu_rvalid}, 64'd1);
    check("t4 rdata", cpu_dout, 64'hDEADBEEF00C0FFEE);
    check("t4 rd be", {56'd0, ch1_be}, 64'hFF);
    check("t5 blocked rdone", {63'd0, cpu_ack}, 64'd0);
    cyc();
    check("t4 rvalid pulse", {63'd0, cpu_rvalid}, 64'd0);
    check("t5 accepted", {63'd0, cpu_ack}, 64'd1);
    cyc();
    cpu_valid = 1'b0;
    check("t5 req", {63'd0, ch1_req}, 64'd1);
    check("t5 addr", {38'd0, ch1_addr}, 64'h300);
    check("t5 be", {56'd0, ch1_be}, 64'h0F);

    // T6: reset during WAIT_W with three writes queued
    present(1'b0, 26'h308, 64'hC1, 8'hFF);
    check("t6 ack a", {63'd0, cpu_ack}, 64'd1);
    cyc();
    present(1'b0, 26'h310, 64'hC2, 8'hFF);
    check("t6 ack b", {63'd0, cpu_ack}, 64'd1);
    cyc();
    cpu_valid = 1'b0;
    check("t6 level3", {61'd0, wq_level}, 64'd3);
    #2 init_n = 1'b0;
    #1;
    check("t6 level async", {61'd0, wq_level}, 64'd0);
    check("t6 req async", {63'd0, ch1_req}, 64'd0);
    check("t6 addr async", {38'd0, ch1_addr}, 64'd0);
    cyc();
    init_n = 1'b1;
    cyc();
    ch1_ready = 1'b1;
    cyc();
    ch1_ready = 1'b0;
    check("t6 stray level", {61'd0, wq_level}, 64'd0);
    check("t6 stray rvalid", {63'd0, cpu_rvalid}, 64'd0);
    check("t6 stray req", {63'd0, ch1_req}, 64'd0);
    cyc();
    check("t6 later rvalid", {63'd0, cpu_rvalid}, 64'd0);
    check("t6 later req", {63'd0, ch1_req}, 64'd0);
    check("t6 later level", {61'd0, wq_level}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
